// File: rtl/rv_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rv_fifo
//  Description : Synchronous valid-ready first-word-fall-through FIFO.
//                Buffers up to `depth` words between a register slice and a
//                slow or bursty consumer. All outputs are functions of
//                registered state and rst only, so no combinational path
//                runs from out_ready to in_ready or from in_valid to
//                out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_fifo #(
    parameter int wd    = 4,
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [wd-1:0]              data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [wd-1:0]              data_out,
    output logic [$clog2(depth):0]     count
);

    localparam int c_aw = $clog2(depth);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_full  = c_cw'(depth);
    localparam logic [c_cw-1:0] c_empty = '0;

    logic [wd-1:0]   r_mem [depth];
    logic [c_aw-1:0] r_wp;
    logic [c_aw-1:0] r_rp;
    logic [c_cw-1:0] r_count;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;

    // Handshake status derived purely from the occupancy register and rst;
    // a full FIFO refuses input even if a pop happens in the same cycle.
    always_comb begin
        w_in_ready  = !rst && (r_count != c_full);
        w_out_valid = !rst && (r_count != c_empty);
        w_push      = in_valid  && w_in_ready;
        w_pop       = out_valid && out_ready;
    end

    // Storage array: written on accepted pushes only, never cleared by reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= data_in;
        end
    end

    // Pointers wrap naturally at depth; occupancy tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output drive: head word is visible whenever valid, zero otherwise;
    // count reads as zero while reset is asserted.
    always_comb begin
        in_ready  = w_in_ready;
        out_valid = w_out_valid;
        data_out  = w_out_valid ? r_mem[r_rp] : '0;
        count     = rst ? '0 : r_count;
    end

endmodule
`default_nettype wire

// File: doc/rv_fifo.md
# rv_fifo

Synchronous valid-ready FIFO that sits directly downstream of the single-stage valid-ready register slice and absorbs its output stream. It decouples the slice from a slow or bursty consumer by buffering up to `depth` words. Ready on the input side never depends combinationally on the output side, so no combinational ready path crosses the block.

## Interface

**Parameters**
- `wd`, default 4: data width in bits.
- `depth`, default 4: number of entries. Must be a power of two and ≥ 2.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream word available on `data_in`.
- `in_ready`, output, 1: FIFO can accept a word this cycle.
- `data_in`, input, `wd`: upstream data.
- `out_valid`, output, 1: a word is presented on `data_out`.
- `out_ready`, input, 1: downstream accepts the presented word.
- `data_out`, output, `wd`: head-of-queue data.
- `count`, output, `$clog2(depth)+1`: current occupancy, 0..`depth`.

## Operation

- Storage: `depth`-entry register array, plus write pointer `wp` and read pointer `rp`, each `$clog2(depth)` bits.
  - Pointers wrap naturally from `depth-1` to 0.
  - `count` is held in its own register.
- Push: occurs when `in_valid && in_ready`. Writes `data_in` to `mem[wp]`; `wp` increments.
- Pop: occurs when `out_valid && out_ready`. `rp` increments.
- Status outputs:
  - `in_ready = !rst && (count != depth)`.
  - `out_valid = (count != 0)`.
  - `data_out = mem[rp]` when `out_valid`, else all zeros.
  - This is first-word-fall-through: the head word is visible without a request.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop occur together, or when neither occurs.
- Simultaneous push and pop at 0 < count < depth: both proceed; `count` is unchanged.
- Full (count == depth):
  - `in_ready` = 0, so no push occurs whatever `in_valid` is.
  - A pop that cycle makes `in_ready` = 1 on the next cycle.
  - A same-cycle push while full is not permitted; `in_ready` does not look at `out_ready`.
- Empty (count == 0):
  - `out_valid` = 0, so no pop occurs whatever `out_ready` is.
  - A push that cycle makes the word visible on the next cycle. There is no bypass.
- Illegal-value safety: state never changes on handshake attempts blocked by full or empty.
- Upstream is expected to hold `in_valid` and `data_in` stable until accepted. The FIFO samples only on the accepting edge.

## Timing

- Reset (`rst` high at an edge):
  - `wp`, `rp`, `count` ← 0.
  - Array contents are not cleared.
  - While `rst` is high: `in_ready` = 0, `out_valid` = 0, `data_out` = 0, `count` = 0.
  - `in_ready` = 1 in the first cycle after `rst` falls.
- Reset mid-operation: all queued words are discarded at that edge. Handshakes presented during the reset cycle have no effect.
- Latency:
  - Input acceptance edge to `out_valid` high: 1 cycle when the FIFO was empty.
  - Pop edge to `in_ready` high: 1 cycle when the FIFO was full.
- Throughput: one word per cycle in each direction concurrently.
- Ordering: strict FIFO order; no word is lost or duplicated.
- All outputs depend only on registered state and `rst`; none depends combinationally on `in_valid` or `out_ready`.

## Test plan

- **Reset:** hold `rst`=1 for 2 cycles with `in_valid`=1 and `data_in`=5 → `in_ready`=0, `out_valid`=0, `data_out`=0, `count`=0 throughout. One cycle after release → `in_ready`=1.
- **Fill to full:** `out_ready`=0, push 5, 15, 10, 3 on consecutive cycles → `count` goes 1, 2, 3, 4 and `in_ready`=0 at count 4. A fifth word 7 held with `in_valid`=1 is not accepted. `data_out`=5 throughout.
- **Drain:** from full, `out_ready`=1 and `in_valid`=0 → `data_out` sequence 5, 15, 10, 3, then `out_valid`=0 and `data_out`=0. `count` goes 3, 2, 1, 0.
- **Concurrent push/pop:** at count 2, hold `in_valid`=1 and `out_ready`=1 for 8 cycles with `data_in` = 0..7 → `count` stays 2; output order is continuous with no gaps. Pointer wrap is exercised.
- **Full with pop:** at count 4, `out_ready`=1 for one cycle while `in_valid`=1 with `data_in`=9 → 9 is not accepted that cycle. It is accepted the next cycle; `count` goes 4, 3, 4.
- **Mid-stream reset:** at count 3, pulse `rst` for one cycle → next cycle `count`=0 and `out_valid`=0. A subsequent push of 12 appears on `data_out` one cycle later.
